// File: rtl/icache_2way.sv
`default_nettype none
// ============================================================================
// Module   : icache_2way
// Purpose  : 2-way set-associative instruction cache. Hits are served
//            combinationally; a miss fetches one whole line from the memory
//            controller and fills the LRU victim way. clear_signal aborts an
//            outstanding miss; flush_signal invalidates the whole cache.
// Optional : define ICACHE_STATS_EN to add hit_count / miss_count outputs.
// Ports    : clk_in, rst_n_in (sync, active-low), rdy_in (low = freeze),
//            clear_signal, flush_signal, fetch_signal, fetch_addr[31:0]
//            -> fetch_done, fetch_instr[31:0] (combinational hit path)
//            mem_signal, mem_addr[31:0] (line request)
//            <- mem_done (one-cycle pulse), mem_data[32*LINE_WORDS-1:0]
//            [ICACHE_STATS_EN] hit_count[31:0], miss_count[31:0]
// Revision : 1.0 - initial release
// ============================================================================
module icache_2way #(
  parameter int LINE_WORDS  = 2,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         clear_signal,
  input  logic                         flush_signal,
  input  logic                         fetch_signal,
  input  logic [31:0]                  fetch_addr,
  output logic                         fetch_done,
  output logic [31:0]                  fetch_instr,
  output logic                         mem_signal,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_done,
  input  logic [32*LINE_WORDS-1:0]     mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
`endif
);

  localparam int WO      = $clog2(LINE_WORDS);
  localparam int SETS    = 2 ** INDEX_WIDTH;
  localparam int LW_BITS = 32 * LINE_WORDS;
  localparam int OFF     = 2 + WO;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  logic [0:0]             state_q, state_d;
  logic                   mem_signal_q, mem_signal_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [INDEX_WIDTH-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_WIDTH-1:0]   miss_tag_q, miss_tag_d;
  logic [SETS-1:0]        valid_q [2];
  logic [SETS-1:0]        valid_d [2];
  logic [SETS-1:0]        lru_q, lru_d;     // bit = way that is least recently used
  logic [TAG_WIDTH-1:0]   tag_q   [2][SETS];
  logic [LW_BITS-1:0]     data_q  [2][SETS];

  // Address decode of the current fetch
  logic [WO-1:0]          f_word;
  logic [INDEX_WIDTH-1:0] f_idx;
  logic [TAG_WIDTH-1:0]   f_tag;
  assign f_word = fetch_addr[2 +: WO];
  assign f_idx  = fetch_addr[OFF +: INDEX_WIDTH];
  assign f_tag  = fetch_addr[OFF+INDEX_WIDTH +: TAG_WIDTH];

  // Byte offset within a word is irrelevant to an instruction cache
  logic unused_byte_bits;
  assign unused_byte_bits = ^fetch_addr[1:0];

  logic hit0, hit1, hit_any;
  assign hit0    = valid_q[0][f_idx] && (tag_q[0][f_idx] == f_tag);
  assign hit1    = valid_q[1][f_idx] && (tag_q[1][f_idx] == f_tag);
  assign hit_any = hit0 || hit1;

  assign fetch_done = fetch_signal && hit_any;

  logic [LW_BITS-1:0] hit_line;
  assign hit_line = hit0 ? data_q[0][f_idx] : data_q[1][f_idx];

  always_comb begin
    fetch_instr = hit_line[31:0];
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (f_word == w[WO-1:0]) fetch_instr = hit_line[w*32 +: 32];
    end
  end

  // Victim: first invalid way, otherwise the LRU way of the latched miss set
  logic victim;
  assign victim = !valid_q[0][miss_idx_q] ? 1'b0 :
                  !valid_q[1][miss_idx_q] ? 1'b1 : lru_q[miss_idx_q];

  logic fill_we;

  always_comb begin
    state_d      = state_q;
    mem_signal_d = mem_signal_q;
    mem_addr_d   = mem_addr_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    valid_d[0]   = valid_q[0];
    valid_d[1]   = valid_q[1];
    lru_d        = lru_q;
    fill_we      = 1'b0;
    if (flush_signal) begin
      valid_d[0]   = '0;
      valid_d[1]   = '0;
      lru_d        = '0;
      state_d      = S_IDLE;
      mem_signal_d = 1'b0;
    end else if (clear_signal) begin
      state_d      = S_IDLE;
      mem_signal_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_signal) begin
            if (hit_any) begin
              lru_d[f_idx] = hit0;  // the way that did not hit becomes LRU
            end else begin
              miss_idx_d   = f_idx;
              miss_tag_d   = f_tag;
              mem_addr_d   = {fetch_addr[31:OFF], {OFF{1'b0}}};
              mem_signal_d = 1'b1;
              state_d      = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (mem_done) begin
            fill_we                     = 1'b1;
            valid_d[victim][miss_idx_q] = 1'b1;
            lru_d[miss_idx_q]           = ~victim;
            mem_signal_d                = 1'b0;
            state_d                     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      mem_signal_q <= 1'b0;
      mem_addr_q   <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      mem_signal_q <= mem_signal_d;
      mem_addr_q   <= mem_addr_d;
      miss_idx_q   <= miss_idx_d;
      miss_tag_q   <= miss_tag_d;
      valid_q[0]   <= valid_d[0];
      valid_q[1]   <= valid_d[1];
      lru_q        <= lru_d;
    end
  end

  // Tag/data arrays need no reset: valid bits gate every use
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in && fill_we) begin
      tag_q[victim][miss_idx_q]  <= miss_tag_q;
      data_q[victim][miss_idx_q] <= mem_data;
    end
  end

  assign mem_signal = mem_signal_q;
  assign mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE && fetch_done) hit_count_d = hit_count_q + 32'd1;
    if (state_q == S_IDLE && state_d == S_FETCH) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (rdy_in) begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_2way.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_2way
// Purpose  : Self-checking bench for icache_2way. A driver issues one cycle of
//            stimulus at a time and pushes the expected outputs (from a
//            recency-list reference model) into a scoreboard queue; a monitor
//            pops and compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_2way;

  localparam int LW   = 2;
  localparam int IW   = 6;
  localparam int TW   = 8;
  localparam int SETS = 2 ** IW;
  localparam int WO   = 1;
  localparam int OFF  = 2 + WO;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rdy = 1'b1;
  logic              clr = 1'b0;
  logic              fl = 1'b0;
  logic              fe = 1'b0;
  logic [31:0]       addr = '0;
  logic              fetch_done;
  logic [31:0]       fetch_instr;
  logic              mem_signal;
  logic [31:0]       mem_addr;
  logic              md = 1'b0;
  logic [32*LW-1:0]  mdata = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0]       hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  icache_2way #(.LINE_WORDS(LW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .clear_signal(clr), .flush_signal(fl), .fetch_signal(fe),
    .fetch_addr(addr), .fetch_done(fetch_done), .fetch_instr(fetch_instr),
    .mem_signal(mem_signal), .mem_addr(mem_addr),
    .mem_done(md), .mem_data(mdata)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Per set: list of resident tags ordered least- to most-recently used.
  int               rec_n [SETS];
  logic [TW-1:0]    rec_t [SETS][2];
  logic [32*LW-1:0] ldata [int];
  bit               m_fetching;
  int               m_set;
  logic [TW-1:0]    m_tag;
  logic [31:0]      m_addr;
  logic [31:0]      m_hits, m_misses;

  typedef struct {
    logic        done;
    logic [31:0] instr;
    logic        ms;
    logic [31:0] ma;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;
  exp_t sb[$];

  function automatic int find(input int s, input logic [TW-1:0] t);
    for (int i = 0; i < rec_n[s]; i++) if (rec_t[s][i] == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) rec_n[s] = 0;
    m_fetching = 0;
    m_addr     = 32'h0;
    m_hits     = 32'h0;
    m_misses   = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; expectation pushed before the model advances.
  task automatic cycle(input logic i_rdy, input logic i_clr, input logic i_fl,
                       input logic i_fe, input logic [31:0] i_addr,
                       input logic i_md, input logic [32*LW-1:0] i_mdata);
    exp_t e;
    int s, w, hitpos;
    logic [TW-1:0] t;
    logic [32*LW-1:0] line;
    @(posedge clk); #1;
    rdy = i_rdy; clr = i_clr; fl = i_fl; fe = i_fe; addr = i_addr;
    md = i_md; mdata = i_mdata;
    s = int'((i_addr >> OFF) % SETS);
    t = TW'(i_addr >> (OFF + IW));
    w = int'((i_addr >> 2) % LW);
    hitpos = find(s, t);
    e.done   = i_fe && (hitpos >= 0);
    e.instr  = 32'h0;
    if (e.done) begin
      line    = ldata[s * 256 + int'(t)];
      e.instr = line[w*32 +: 32];
    end
    e.ms     = m_fetching;
    e.ma     = m_addr;
    e.hits   = m_hits;
    e.misses = m_misses;
    sb.push_back(e);
    if (i_rdy) begin
      if (!m_fetching && e.done) m_hits++;
      if (i_fl) begin
        for (int k = 0; k < SETS; k++) rec_n[k] = 0;
        m_fetching = 0;
      end else if (i_clr) begin
        m_fetching = 0;
      end else if (!m_fetching) begin
        if (i_fe && hitpos >= 0) begin
          if (rec_n[s] == 2 && hitpos == 0) begin
            rec_t[s][0] = rec_t[s][1];
            rec_t[s][1] = t;
          end
        end else if (i_fe) begin
          m_fetching = 1;
          m_set  = s;
          m_tag  = t;
          m_addr = i_addr & ~32'h7;
          m_misses++;
        end
      end else if (i_md) begin
        if (rec_n[m_set] < 2) begin
          rec_t[m_set][rec_n[m_set]] = m_tag;
          rec_n[m_set]++;
        end else begin
          rec_t[m_set][0] = rec_t[m_set][1];
          rec_t[m_set][1] = m_tag;
        end
        ldata[m_set * 256 + int'(m_tag)] = i_mdata;
        m_fetching = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; rdy = 1'b1; clr = 0; fl = 0; fe = 0; md = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [32*LW-1:0] rline();
    return {$urandom, $urandom};
  endfunction

  // Miss then fill on the next cycle
  task automatic fill(input logic [31:0] a);
    cycle(1, 0, 0, 1, a, 0, '0);
    cycle(1, 0, 0, 0, 32'h0, 1, rline());
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("fetch_done", {31'h0, fetch_done}, {31'h0, e.done});
      if (e.done) check("fetch_instr", fetch_instr, e.instr);
      check("mem_signal", {31'h0, mem_signal}, {31'h0, e.ms});
      check("mem_addr", mem_addr, e.ma);
`ifdef ICACHE_STATS_EN
      check("hit_count", hit_count, e.hits);
      check("miss_count", miss_count, e.misses);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // Cold miss, fill, hits on both words
    cycle(1, 0, 0, 1, 32'h0000_0000, 0, '0);
    cycle(1, 0, 0, 0, 32'h0, 0, '0);
    cycle(1, 0, 0, 0, 32'h0, 1, 64'h00A00093_00100013);
    cycle(1, 0, 0, 1, 32'h0000_0000, 0, '0);
    @(negedge clk);
    check("hit_word0", fetch_instr, 32'h00100013);
    cycle(1, 0, 0, 1, 32'h0000_0004, 0, '0);
    @(negedge clk);
    check("hit_word1", fetch_instr, 32'h00A00093);
    check("no_req_on_hit", {31'h0, mem_signal}, 32'h0);

    // LRU eviction in set 0
    fill(32'h0000_0200);
    cycle(1, 0, 0, 1, 32'h0000_0000, 0, '0);
    fill(32'h0000_0400);
    cycle(1, 0, 0, 1, 32'h0000_0200, 0, '0);
    @(negedge clk);
    check("evicted_0200", {31'h0, fetch_done}, 32'h0);
    cycle(1, 1, 0, 0, 32'h0, 0, '0);
    cycle(1, 0, 0, 1, 32'h0000_0000, 0, '0);
    @(negedge clk);
    check("kept_0000", {31'h0, fetch_done}, 32'h1);

    // Clear coinciding with mem_done drops the fill
    cycle(1, 0, 0, 1, 32'h0000_0010, 0, '0);
    cycle(1, 1, 0, 0, 32'h0, 1, rline());
    cycle(1, 0, 0, 1, 32'h0000_0010, 0, '0);
    cycle(1, 0, 0, 0, 32'h0, 0, '0);
    @(negedge clk);
    check("reissue_addr", mem_addr, 32'h0000_0010);
    cycle(1, 0, 0, 0, 32'h0, 1, rline());

    // Flush invalidates; flush during FETCH drops the fill
    fill(32'h0000_0008);
    cycle(1, 0, 1, 0, 32'h0, 0, '0);
    cycle(1, 0, 0, 1, 32'h0000_0008, 0, '0);
    cycle(1, 0, 1, 0, 32'h0, 1, rline());
    cycle(1, 0, 0, 1, 32'h0000_0008, 0, '0);
    @(negedge clk);
    check("flush_drop_fill", {31'h0, fetch_done}, 32'h0);
    cycle(1, 1, 0, 0, 32'h0, 0, '0);

    // rdy_in low freezes a pending miss
    cycle(1, 0, 0, 1, 32'h0000_0800, 0, '0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 32'h0, (i == 2), rline());
    @(negedge clk);
    check("frozen_ms", {31'h0, mem_signal}, 32'h1);
    check("frozen_ma", mem_addr, 32'h0000_0800);
    cycle(1, 0, 0, 0, 32'h0, 1, rline());
    cycle(1, 0, 0, 1, 32'h0000_0804, 0, '0);

    // Randomised traffic with occasional mid-run reset
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      if (n == 1500) do_reset();
      a = ($urandom & 32'hFFFE_0000)
        | ($urandom_range(0, 3) << (OFF + IW))
        | ($urandom_range(0, 3) << OFF)
        | ($urandom_range(0, LW - 1) << 2)
        | ($urandom & 32'h3);
      cycle(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 7),
            a,
            ($urandom_range(0, 3) == 0),
            rline());
    end

    cycle(1, 0, 0, 0, 32'h0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Parametrised 2-way set-associative instruction cache with a configurable line size; next generation of the direct-mapped instruction cache.
- Sits between instruction fetch and the memory controller.
- Hit path is combinational: a hit returns its instruction in the same cycle.
- Misses fetch one whole line from the memory controller and fill the LRU victim way. Supports abort (clear) and full invalidate (flush).

Parameters:
LINE_WORDS, 2, 32-bit instructions per line; power of two, >=2
INDEX_WIDTH, 6, set index bits (SETS = 2**INDEX_WIDTH)
TAG_WIDTH, 8, stored tag bits; address bits above the tag are ignored and alias
WO (localparam), $clog2(LINE_WORDS), word-offset bits

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, synchronous, active-low
rdy_in  input  1  ready; low freezes all state
clear_signal  input  1  prediction error; aborts any outstanding miss
flush_signal  input  1  invalidate whole cache (fence.i)
fetch_signal  input  1  fetch request
fetch_addr  input  32  instruction address
fetch_done  output  1  hit, combinational
fetch_instr  output  32  hit instruction, combinational
mem_signal  output  1  line request to the memory controller
mem_addr  output  32  line-aligned request address
mem_done  input  1  line returned, one-cycle pulse
mem_data  input  32*LINE_WORDS  line data; word 0 in bits [31:0]

Behaviour:
- Address fields:
  - word = addr[2 +: WO]
  - index = addr[2+WO +: INDEX_WIDTH]
  - tag = addr[2+WO+INDEX_WIDTH +: TAG_WIDTH]
  - addr[1:0] ignored
- Storage per set: valid[2], tag[2], data[2], one lru bit. The lru bit names the least-recently-used way.
- Hit rule: fetch_done = fetch_signal & OR over ways of (valid & tag match). fetch_instr = word of the hitting way; value is don't-care when fetch_done=0. Hits are reported in any state.
- Reset (rst_n_in=0 at posedge; overrides rdy_in):
  - state=IDLE, mem_signal=0, mem_addr=0
  - all valid=0, all lru=0
- rdy_in=0: no state, array, LRU or output-register change.
- States:
  - IDLE:
    - fetch_signal & hit: set lru[index] to the non-hitting way.
    - fetch_signal & miss: latch miss index/tag, set mem_addr = fetch_addr with low 2+WO bits zeroed, mem_signal<=1, go to FETCH.
  - FETCH:
    - mem_signal held 1 and mem_addr held stable until mem_done.
    - On mem_done: write the victim way. Victim = way 0 if invalid, else way 1 if invalid, else the lru way.
    - Write valid=1, tag = latched miss tag (never taken from mem_data), data=mem_data. Set lru to the other way.
    - Then mem_signal<=0, go to IDLE.
  - Latency: a miss raises mem_signal the cycle after detection. The fill is visible (fetch_done=1 for the same fetch_addr) in the cycle after mem_done.
- Priority per cycle (rdy_in=1): flush_signal > clear_signal > normal operation.
  - clear: state<=IDLE, mem_signal<=0. A mem_done in the same cycle is dropped (no write). Arrays otherwise untouched.
  - flush: all valid<=0, all lru<=0, state<=IDLE, mem_signal<=0. Any concurrent fill is dropped.
- An IDLE hit and a miss cannot coincide (single port).
- In FETCH, fetch_addr may change; the fill still targets the latched miss set.
- mem_done is ignored while in IDLE.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both 0 on reset and wrapping at 2**32.
  - hit_count increments each rdy_in cycle with fetch_done=1 in IDLE.
  - miss_count increments on each IDLE->FETCH transition.
  - Neither counter is affected by flush or clear.
- Undefined: the ports and the logic are absent; all other behaviour is identical.

Test Plan (defaults: index=addr[8:3], tag=addr[16:9]):
- Reset, then fetch 0x0000 -> fetch_done=0; next cycle mem_signal=1, mem_addr=0x0000. mem_done with mem_data=0x00A00093_00100013 -> next cycle fetch_done=1, fetch_instr=0x00100013; fetch 0x0004 -> 0x00A00093 with no mem request.
- Fill 0x0000, 0x0200, 0x0400 (all set 0) with a hit on 0x0000 before 0x0400 -> 0x0400 evicts the 0x0200 way. Fetch 0x0200 misses; fetch 0x0000 hits.
- Miss on 0x0010, assert clear_signal in the same cycle as mem_done -> mem_signal=0 next cycle; fetch 0x0010 misses again, with a new request to mem_addr=0x0010.
- Fill sets 0 and 1, pulse flush_signal -> all fetches miss. Flush during FETCH -> mem_signal drops and no line is written.
- Hold rdy_in=0 for 5 cycles during FETCH with mem_done pulsed -> no fill; state, mem_signal=1 and mem_addr unchanged.
- ICACHE_STATS_EN: 3 misses then 4 hits -> miss_count=3, hit_count=4; after flush, both counts are unchanged.
